// File: rtl/seg_scroll_ring.sv
// Nibble-ring scroller for the seven-segment path: loadable hex message, prescaled or stepped rotation, display window and wrap pulse.
// Optional feature macro: SCROLL_BLANK_PAD_EN (adds DISP_NIBBLES blank pad digits above the message).
module seg_scroll_ring #(
    parameter int         MSG_NIBBLES  = 5,
    parameter int         DISP_NIBBLES = 4,
    parameter int         RATE_DIV     = 33_333_333,
    parameter logic [3:0] BLANK_CODE   = 4'hC
) (
    input  logic                      clk,
    input  logic                      clr,
    input  logic                      load,
    input  logic [4*MSG_NIBBLES-1:0]  scroll_datain,
    input  logic                      run,
    input  logic                      dir,
    input  logic                      step,
    output logic [4*DISP_NIBBLES-1:0] scroll_dataout,
    output logic                      tick,
    output logic                      wrap
);

`ifdef SCROLL_BLANK_PAD_EN
    localparam int RING = MSG_NIBBLES + DISP_NIBBLES;
`else
    localparam int RING = MSG_NIBBLES;
`endif
    localparam int RING_W = 4 * RING;
    localparam int POS_W  = (RING > 1) ? $clog2(RING) : 1;
    localparam int DIV_W  = (RATE_DIV > 1) ? $clog2(RATE_DIV) : 1;
    localparam logic [POS_W-1:0] POS_LAST = POS_W'(RING - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RATE_DIV - 1);

    logic [RING_W-1:0] ring_r;
    logic [RING_W-1:0] ring_n_s;
    logic [RING_W-1:0] load_img_s;
    logic [RING_W-1:0] rst_img_s;
    logic [POS_W-1:0]  pos_r;
    logic [POS_W-1:0]  pos_n_s;
    logic [DIV_W-1:0]  div_cnt_r;
    logic [DIV_W-1:0]  div_n_s;
    logic              tick_r;
    logic              wrap_r;
    logic              tick_n_s;
    logic              wrap_n_s;
    logic              tick_hit_s;
    logic              shift_s;

    // Rotations are taken from a doubled ring so a single-digit ring still works.
    function automatic logic [RING_W-1:0] rot_right(input logic [RING_W-1:0] r);
        logic [2*RING_W-1:0] d;
        d = {r, r} >> 3'd4;
        return d[RING_W-1:0];
    endfunction

    function automatic logic [RING_W-1:0] rot_left(input logic [RING_W-1:0] r);
        logic [2*RING_W-1:0] d;
        d = {r, r} << 3'd4;
        return d[2*RING_W-1:RING_W];
    endfunction

`ifdef SCROLL_BLANK_PAD_EN
    assign load_img_s = {{DISP_NIBBLES{BLANK_CODE}}, scroll_datain};
    assign rst_img_s  = {{DISP_NIBBLES{BLANK_CODE}}, {(4*MSG_NIBBLES){1'b0}}};
`else
    logic [3:0] unused_blank_s;
    assign unused_blank_s = BLANK_CODE;
    assign load_img_s     = scroll_datain;
    assign rst_img_s      = {RING_W{1'b0}};
`endif

    // Next-state: load beats any shift; tick and step merge into one shift.
    always_comb begin
        tick_hit_s = run && (div_cnt_r == DIV_LAST);
        shift_s    = tick_hit_s || step;
        ring_n_s   = ring_r;
        pos_n_s    = pos_r;
        div_n_s    = div_cnt_r;
        tick_n_s   = 1'b0;
        wrap_n_s   = 1'b0;
        if (load) begin
            ring_n_s = load_img_s;
            pos_n_s  = {POS_W{1'b0}};
            div_n_s  = {DIV_W{1'b0}};
        end else begin
            if (run) begin
                div_n_s = tick_hit_s ? {DIV_W{1'b0}} : div_cnt_r + DIV_W'(1);
            end else begin
                div_n_s = {DIV_W{1'b0}};
            end
            tick_n_s = tick_hit_s;
            if (shift_s) begin
                if (dir) begin
                    ring_n_s = rot_left(ring_r);
                    pos_n_s  = (pos_r == {POS_W{1'b0}}) ? POS_LAST : pos_r - POS_W'(1);
                end else begin
                    ring_n_s = rot_right(ring_r);
                    pos_n_s  = (pos_r == POS_LAST) ? {POS_W{1'b0}} : pos_r + POS_W'(1);
                end
                wrap_n_s = (pos_n_s == {POS_W{1'b0}});
            end else begin
                wrap_n_s = 1'b0;
            end
        end
    end

    // State and output registers with synchronous clear.
    always_ff @(posedge clk) begin
        if (clr) begin
            ring_r    <= rst_img_s;
            pos_r     <= {POS_W{1'b0}};
            div_cnt_r <= {DIV_W{1'b0}};
            tick_r    <= 1'b0;
            wrap_r    <= 1'b0;
        end else begin
            ring_r    <= ring_n_s;
            pos_r     <= pos_n_s;
            div_cnt_r <= div_n_s;
            tick_r    <= tick_n_s;
            wrap_r    <= wrap_n_s;
        end
    end

    assign scroll_dataout = ring_r[4*DISP_NIBBLES-1:0];
    assign tick           = tick_r;
    assign wrap           = wrap_r;

endmodule

// File: tb/tb_seg_scroll_ring.sv
// Directed bench for seg_scroll_ring with RATE_DIV=4; the SCROLL_BLANK_PAD_EN build runs the pad sequence instead.
module tb_seg_scroll_ring;

    logic        clk;
    logic        clr;
    logic        load;
    logic [19:0] scroll_datain;
    logic        run;
    logic        dir;
    logic        step;
    logic [15:0] scroll_dataout;
    logic        tick;
    logic        wrap;

    int err_cnt;
    int chk_cnt;

    seg_scroll_ring #(
        .MSG_NIBBLES (5),
        .DISP_NIBBLES(4),
        .RATE_DIV    (4),
        .BLANK_CODE  (4'hC)
    ) dut (
        .clk           (clk),
        .clr           (clr),
        .load          (load),
        .scroll_datain (scroll_datain),
        .run           (run),
        .dir           (dir),
        .step          (step),
        .scroll_dataout(scroll_dataout),
        .tick          (tick),
        .wrap          (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [19:0] val);
        load          = 1'b1;
        scroll_datain = val;
        cyc();
        load = 1'b0;
    endtask

    task automatic idle_cycles(input int n, input logic [15:0] win);
        for (int k = 0; k < n; k++) begin
            cyc();
            check_val("idle_tick", {31'd0, tick}, 32'd0);
            check_val("idle_win", {16'd0, scroll_dataout}, {16'd0, win});
        end
    endtask

`ifndef SCROLL_BLANK_PAD_EN
    logic [15:0] right_win [5] = '{16'h1234, 16'h5123, 16'h4512, 16'h3451, 16'h2345};
    logic [15:0] step_win  [3] = '{16'h1234, 16'h5123, 16'h4512};
`else
    logic [15:0] pad_win [9] = '{16'h1234, 16'hC123, 16'hCC12, 16'hCCC1, 16'hCCCC,
                                 16'h5CCC, 16'h45CC, 16'h345C, 16'h2345};
`endif

    initial begin
        err_cnt       = 0;
        chk_cnt       = 0;
        clr           = 1'b1;
        load          = 1'b0;
        scroll_datain = 20'h0;
        run           = 1'b0;
        dir           = 1'b0;
        step          = 1'b0;
        cyc();
        cyc();
        check_val("rst_win", {16'd0, scroll_dataout}, 32'd0);
        check_val("rst_tick", {31'd0, tick}, 32'd0);
        check_val("rst_wrap", {31'd0, wrap}, 32'd0);
        clr = 1'b0;

`ifndef SCROLL_BLANK_PAD_EN
        // Load with run low, then hold without steps
        do_load(20'h12345);
        check_val("load_win", {16'd0, scroll_dataout}, 32'h2345);
        check_val("load_tick", {31'd0, tick}, 32'd0);
        idle_cycles(20, 16'h2345);

        // Automatic right scroll, tick every 4 cycles, wrap on fifth shift
        run = 1'b1;
        for (int i = 0; i < 5; i++) begin
            idle_cycles(3, (i == 0) ? 16'h2345 : right_win[i-1]);
            cyc();
            check_val("rs_tick", {31'd0, tick}, 32'd1);
            check_val("rs_win", {16'd0, scroll_dataout}, {16'd0, right_win[i]});
            check_val("rs_wrap", {31'd0, wrap}, (i == 4) ? 32'd1 : 32'd0);
        end
        run = 1'b0;
        cyc();

        // Left scroll from a fresh load
        dir = 1'b1;
        do_load(20'h12345);
        run = 1'b1;
        idle_cycles(3, 16'h2345);
        cyc();
        check_val("ls_win1", {16'd0, scroll_dataout}, 32'h3451);
        check_val("ls_wrap1", {31'd0, wrap}, 32'd0);
        idle_cycles(3, 16'h3451);
        cyc();
        check_val("ls_win2", {16'd0, scroll_dataout}, 32'h4512);
        run = 1'b0;
        dir = 1'b0;
        cyc();

        // Load on the same edge as a tick discards the shift and restarts the prescaler
        do_load(20'h12345);
        run = 1'b1;
        idle_cycles(3, 16'h2345);
        do_load(20'hABCDE);
        check_val("lt_win", {16'd0, scroll_dataout}, 32'hBCDE);
        check_val("lt_tick", {31'd0, tick}, 32'd0);
        check_val("lt_wrap", {31'd0, wrap}, 32'd0);
        idle_cycles(3, 16'hBCDE);
        cyc();
        check_val("lt_next_tick", {31'd0, tick}, 32'd1);
        check_val("lt_next_win", {16'd0, scroll_dataout}, 32'hABCD);
        run = 1'b0;
        cyc();

        // Step held for 3 cycles with run low
        do_load(20'h12345);
        step = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check_val("step_win", {16'd0, scroll_dataout}, {16'd0, step_win[i]});
            check_val("step_tick", {31'd0, tick}, 32'd0);
        end
        step = 1'b0;
        cyc();
        check_val("step_hold", {16'd0, scroll_dataout}, 32'h4512);

        // Direction reversal walks position back to 0 and wraps
        do_load(20'h12345);
        step = 1'b1;
        dir  = 1'b1;
        cyc();
        check_val("rev_win1", {16'd0, scroll_dataout}, 32'h3451);
        check_val("rev_wrap1", {31'd0, wrap}, 32'd0);
        dir = 1'b0;
        cyc();
        check_val("rev_win2", {16'd0, scroll_dataout}, 32'h2345);
        check_val("rev_wrap2", {31'd0, wrap}, 32'd1);
        step = 1'b0;
        cyc();
        check_val("rev_wrap3", {31'd0, wrap}, 32'd0);

        // Step coincident with tick gives a single shift
        do_load(20'h12345);
        run = 1'b1;
        idle_cycles(3, 16'h2345);
        step = 1'b1;
        cyc();
        check_val("co_tick", {31'd0, tick}, 32'd1);
        check_val("co_win", {16'd0, scroll_dataout}, 32'h1234);
        step = 1'b0;
        cyc();
        check_val("co_after", {16'd0, scroll_dataout}, 32'h1234);

        // Clear on a tick edge overrides the shift
        cyc();
        cyc();
        clr = 1'b1;
        cyc();
        check_val("clr_win", {16'd0, scroll_dataout}, 32'd0);
        check_val("clr_tick", {31'd0, tick}, 32'd0);
        check_val("clr_wrap", {31'd0, wrap}, 32'd0);
        clr = 1'b0;
        run = 1'b0;
`else
        // Padded ring: message scrolls off through blank digits, wrap after 9 shifts
        do_load(20'h12345);
        check_val("pad_load", {16'd0, scroll_dataout}, 32'h2345);
        step = 1'b1;
        for (int i = 0; i < 9; i++) begin
            cyc();
            check_val("pad_win", {16'd0, scroll_dataout}, {16'd0, pad_win[i]});
            check_val("pad_wrap", {31'd0, wrap}, (i == 8) ? 32'd1 : 32'd0);
        end
        cyc();
        cyc();
        check_val("pad_win_c12", {16'd0, scroll_dataout}, 32'hC123);
        step = 1'b0;
        clr  = 1'b1;
        cyc();
        check_val("pad_clr", {16'd0, scroll_dataout}, 32'd0);
        clr = 1'b0;
`endif
        cyc();
        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
